usb_packet_decoder: RTL and testbench

Byte-level USB full-speed packet decoder between the receive byte deserializer (NRZI decode and bit unstuffing) and the endpoint handlers, including the EP0 control handler.
- Validates the PID check nibble, CRC5 on tokens and CRC16 on data packets.
- Extracts token address and endpoint.
- Streams data payload bytes with the two CRC bytes stripped.
- Emits single-cycle completion and error strobes per packet.

---
 rtl/usb_packet_decoder_if.sv | 36 +++
 rtl/usb_packet_decoder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_usb_packet_decoder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_packet_decoder_if.sv
// Byte stream from the receive deserializer plus the decoded packet results.
// master drives the byte stream; slave is the decoder.
interface usb_packet_decoder_if;
  logic        packet_start;
  logic        packet_end;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        rx_error;
  logic [3:0]  pid;
  logic        pid_valid;
  logic [6:0]  token_addr;
  logic [3:0]  token_endp;
  logic        token_valid;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        data_complete;
  logic        data_error;
  logic        handshake_complete;
  logic        packet_error;
  logic [10:0] frame_num;
  logic        sof_valid;

  modport master (
    output packet_start, packet_end, byte_in, byte_valid, rx_error,
    input  pid, pid_valid, token_addr, token_endp, token_valid,
    input  data_out, data_out_valid, data_complete, data_error,
    input  handshake_complete, packet_error, frame_num, sof_valid
  );

  modport slave (
    input  packet_start, packet_end, byte_in, byte_valid, rx_error,
    output pid, pid_valid, token_addr, token_endp, token_valid,
    output data_out, data_out_valid, data_complete, data_error,
    output handshake_complete, packet_error, frame_num, sof_valid
  );
endinterface

// File: rtl/usb_packet_decoder.sv
// USB full-speed byte-level packet decoder: PID check, CRC5/CRC16, token fields, payload streaming.
// Optional macro USB_SOF_DECODE_EN enables SOF frame number decode (frame_num/sof_valid).
module usb_packet_decoder #(
  parameter int MAX_DATA_BYTES = 64,
  parameter int CNT_W          = $clog2(MAX_DATA_BYTES + 3)
) (
  input  logic               clk48,
  input  logic               reset_n,
  usb_packet_decoder_if.slave bus
);

  typedef enum logic [3:0] {
    PID_RSVD  = 4'h0, PID_OUT   = 4'h1, PID_ACK   = 4'h2, PID_DATA0 = 4'h3,
    PID_PING  = 4'h4, PID_SOF   = 4'h5, PID_NYET  = 4'h6, PID_DATA2 = 4'h7,
    PID_SPLIT = 4'h8, PID_IN    = 4'h9, PID_NAK   = 4'hA, PID_DATA1 = 4'hB,
    PID_PRE   = 4'hC, PID_SETUP = 4'hD, PID_STALL = 4'hE, PID_MDATA = 4'hF
  } pid_t;

  typedef enum logic [2:0] {
    PD_IDLE, PD_PID, PD_TOKEN, PD_DATA, PD_HANDSHAKE, PD_DROP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_LIM   = CNT_W'(MAX_DATA_BYTES + 2);
  localparam logic [4:0]       CRC5_RES  = 5'b01100;
  localparam logic [15:0]      CRC16_RES = 16'h800D;

  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] b);
    logic [4:0] c;
    logic       fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = b[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = b[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t           state_q, state_d, state_b;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_b;
  logic             is_data_q, is_data_d;
  logic [4:0]       crc5_q, crc5_d, crc5_b;
  logic [15:0]      crc16_q, crc16_d, crc16_b;
  logic [15:0]      tok_q, tok_d, tok_b;
  logic [7:0]       hold0_q, hold0_d, hold1_q, hold1_d;

  logic [3:0]  pid_q, pid_d;
  logic        pid_valid_q, pid_valid_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  endp_q, endp_d;
  logic        tok_valid_q, tok_valid_d;
  logic [7:0]  dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic        dcomp_q, dcomp_d;
  logic        derr_q, derr_d;
  logic        hs_q, hs_d;
  logic        perr_q, perr_d;
  logic [10:0] frame_q, frame_d;
  logic        sof_q, sof_d;

  always_comb begin
    state_d      = state_q;
    state_b      = state_q;
    cnt_b        = cnt_q;
    is_data_d    = is_data_q;
    crc5_b       = crc5_q;
    crc16_b      = crc16_q;
    tok_b        = tok_q;
    hold0_d      = hold0_q;
    hold1_d      = hold1_q;
    pid_d        = pid_q;
    pid_valid_d  = 1'b0;
    addr_d       = addr_q;
    endp_d       = endp_q;
    tok_valid_d  = 1'b0;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    dcomp_d      = 1'b0;
    derr_d       = 1'b0;
    hs_d         = 1'b0;
    perr_d       = 1'b0;
    frame_d      = frame_q;
    sof_d        = 1'b0;

    if (state_q == PD_IDLE) begin
      if (bus.packet_start) begin
        state_d   = PD_PID;
        cnt_b     = '0;
        crc5_b    = 5'h1F;
        crc16_b   = 16'hFFFF;
        is_data_d = 1'b0;
      end
    end else if (bus.packet_start) begin
      // Abort the packet in flight and restart decoding on this SOP.
      derr_d    = is_data_q;
      perr_d    = !is_data_q;
      state_d   = PD_PID;
      cnt_b     = '0;
      crc5_b    = 5'h1F;
      crc16_b   = 16'hFFFF;
      is_data_d = 1'b0;
    end else if (bus.rx_error) begin
      state_d = bus.packet_end ? PD_IDLE : PD_DROP;
      derr_d  = bus.packet_end & is_data_q;
      perr_d  = bus.packet_end & !is_data_q;
    end else begin
      if (bus.byte_valid) begin
        case (state_q)
          PD_PID: begin
            if (bus.byte_in[7:4] != ~bus.byte_in[3:0]) begin
              state_b = PD_DROP;
            end else begin
              pid_d       = bus.byte_in[3:0];
              pid_valid_d = 1'b1;
              case (bus.byte_in[3:0])
                PID_OUT, PID_IN, PID_SETUP, PID_SOF: state_b = PD_TOKEN;
                PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: begin
                  state_b   = PD_DATA;
                  is_data_d = 1'b1;
                end
                PID_ACK, PID_NAK, PID_STALL, PID_NYET: state_b = PD_HANDSHAKE;
                default: state_b = PD_DROP;
              endcase
            end
          end
          PD_TOKEN: begin
            cnt_b  = sat_inc(cnt_q);
            crc5_b = crc5_byte(crc5_q, bus.byte_in);
            tok_b  = {bus.byte_in, tok_q[15:8]};
          end
          PD_DATA: begin
            cnt_b   = sat_inc(cnt_q);
            crc16_b = crc16_byte(crc16_q, bus.byte_in);
            // The two newest bytes may be the CRC, so only the oldest is released.
            if (cnt_q >= CNT_TWO && cnt_q < CNT_LIM) begin
              dout_d       = hold0_q;
              dout_valid_d = 1'b1;
            end
            hold0_d = hold1_q;
            hold1_d = bus.byte_in;
          end
          PD_HANDSHAKE: state_b = PD_DROP;
          default: ;
        endcase
      end

      if (bus.packet_end) begin
        state_d = PD_IDLE;
        case (state_b)
          PD_TOKEN: begin
            if (cnt_b == CNT_TWO && crc5_b == CRC5_RES) begin
              if (pid_q == PID_SOF) begin
`ifdef USB_SOF_DECODE_EN
                sof_d   = 1'b1;
                frame_d = tok_b[10:0];
`else
                sof_d   = 1'b0;
`endif
              end else begin
                tok_valid_d = 1'b1;
                addr_d      = tok_b[6:0];
                endp_d      = tok_b[10:7];
              end
            end else begin
              perr_d = 1'b1;
            end
          end
          PD_DATA: begin
            if (cnt_b >= CNT_TWO && cnt_b <= CNT_LIM && crc16_b == CRC16_RES)
              dcomp_d = 1'b1;
            else
              derr_d  = 1'b1;
          end
          PD_HANDSHAKE: hs_d = 1'b1;
          default: begin
            derr_d = is_data_d;
            perr_d = !is_data_d;
          end
        endcase
      end else begin
        state_d = state_b;
      end
    end

    cnt_d   = cnt_b;
    crc5_d  = crc5_b;
    crc16_d = crc16_b;
    tok_d   = tok_b;
  end

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= PD_IDLE;
      cnt_q        <= '0;
      is_data_q    <= 1'b0;
      pid_q        <= '0;
      pid_valid_q  <= 1'b0;
      addr_q       <= '0;
      endp_q       <= '0;
      tok_valid_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dcomp_q      <= 1'b0;
      derr_q       <= 1'b0;
      hs_q         <= 1'b0;
      perr_q       <= 1'b0;
      frame_q      <= '0;
      sof_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_data_q    <= is_data_d;
      pid_q        <= pid_d;
      pid_valid_q  <= pid_valid_d;
      addr_q       <= addr_d;
      endp_q       <= endp_d;
      tok_valid_q  <= tok_valid_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dcomp_q      <= dcomp_d;
      derr_q       <= derr_d;
      hs_q         <= hs_d;
      perr_q       <= perr_d;
      frame_q      <= frame_d;
      sof_q        <= sof_d;
    end
  end

  // Datapath holding registers are always initialised at SOP before use.
  always_ff @(posedge clk48) begin
    crc5_q  <= crc5_d;
    crc16_q <= crc16_d;
    tok_q   <= tok_d;
    hold0_q <= hold0_d;
    hold1_q <= hold1_d;
  end

  assign bus.pid                = pid_q;
  assign bus.pid_valid          = pid_valid_q;
  assign bus.token_addr         = addr_q;
  assign bus.token_endp         = endp_q;
  assign bus.token_valid        = tok_valid_q;
  assign bus.data_out           = dout_q;
  assign bus.data_out_valid     = dout_valid_q;
  assign bus.data_complete      = dcomp_q;
  assign bus.data_error         = derr_q;
  assign bus.handshake_complete = hs_q;
  assign bus.packet_error       = perr_q;
  assign bus.frame_num          = frame_q;
  assign bus.sof_valid          = sof_q;

endmodule

// File: tb/tb_usb_packet_decoder.sv
// Directed bench for usb_packet_decoder (default build, SOF decode disabled).
module tb_usb_packet_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  usb_packet_decoder_if bus();

  usb_packet_decoder dut (
    .clk48  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int n_pidv = 0, n_tokv = 0, n_dov = 0, n_dcomp = 0;
  int n_derr = 0, n_hs = 0, n_perr = 0, n_sof = 0;
  logic [3:0] last_pid = '0;
  logic [7:0] dq[$];

  int b_pidv, b_tokv, b_dov, b_dcomp, b_derr, b_hs, b_perr, b_sof, b_dq;
  logic [7:0] pkt[$];

  always @(negedge clk) begin
    if (bus.pid_valid) begin
      n_pidv++;
      last_pid = bus.pid;
    end
    if (bus.token_valid)        n_tokv++;
    if (bus.data_complete)      n_dcomp++;
    if (bus.data_error)         n_derr++;
    if (bus.handshake_complete) n_hs++;
    if (bus.packet_error)       n_perr++;
    if (bus.sof_valid)          n_sof++;
    if (bus.data_out_valid) begin
      n_dov++;
      dq.push_back(bus.data_out);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.packet_start = 1'b0;
    bus.packet_end   = 1'b0;
    bus.byte_in      = 8'h00;
    bus.byte_valid   = 1'b0;
    bus.rx_error     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clr();
    end
  endtask

  task automatic p_start();
    @(negedge clk); clr(); bus.packet_start = 1'b1;
  endtask

  task automatic p_byte(input logic [7:0] b);
    @(negedge clk); clr(); bus.byte_in = b; bus.byte_valid = 1'b1;
  endtask

  task automatic p_err();
    @(negedge clk); clr(); bus.rx_error = 1'b1;
  endtask

  task automatic p_end();
    @(negedge clk); clr(); bus.packet_end = 1'b1;
    idle(4);
  endtask

  task automatic send_pkt();
    p_start();
    foreach (pkt[i]) p_byte(pkt[i]);
    p_end();
  endtask

  task automatic snap();
    b_pidv = n_pidv; b_tokv = n_tokv; b_dov = n_dov; b_dcomp = n_dcomp;
    b_derr = n_derr; b_hs = n_hs; b_perr = n_perr; b_sof = n_sof;
    b_dq = dq.size();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_a"}, {bus.pid, bus.pid_valid, bus.token_addr, bus.token_endp,
                        bus.token_valid, bus.data_out}, 32'h0);
    check({tag, "_b"}, {bus.data_out_valid, bus.data_complete, bus.data_error,
                        bus.handshake_complete, bus.packet_error, bus.frame_num,
                        bus.sof_valid}, 32'h0);
  endtask

  logic [7:0] exp_pl [8] = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};

  initial begin
    clr();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_init");
    rst_n = 1'b1;
    idle(2);

    // SETUP addr 0 endp 0
    snap(); pkt = '{8'h2D, 8'h00, 8'h10}; send_pkt();
    check("setup_pidv", n_pidv - b_pidv, 1);
    check("setup_pid", last_pid, 4'hD);
    check("setup_tokv", n_tokv - b_tokv, 1);
    check("setup_addr", bus.token_addr, 0);
    check("setup_endp", bus.token_endp, 0);
    check("setup_perr", n_perr - b_perr, 0);

    // OUT addr 5 endp 2
    snap(); pkt = '{8'hE1, 8'h05, 8'hF9}; send_pkt();
    check("out_tokv", n_tokv - b_tokv, 1);
    check("out_addr", bus.token_addr, 7'h05);
    check("out_endp", bus.token_endp, 4'h2);
    check("out_perr", n_perr - b_perr, 0);

    // SOF frame 0: pid_valid only in this build
    snap(); pkt = '{8'hA5, 8'h00, 8'h10}; send_pkt();
    check("sof_pidv", n_pidv - b_pidv, 1);
    check("sof_tokv", n_tokv - b_tokv, 0);
    check("sof_perr", n_perr - b_perr, 0);
    check("sof_valid", n_sof - b_sof, 0);
    check("sof_addr_kept", bus.token_addr, 7'h05);

    // Token with corrupted CRC
    snap(); pkt = '{8'h2D, 8'h00, 8'h11}; send_pkt();
    check("badcrc5_tokv", n_tokv - b_tokv, 0);
    check("badcrc5_perr", n_perr - b_perr, 1);

    // DATA0 8-byte payload, good CRC16
    snap();
    pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    send_pkt();
    check("d0_dov", n_dov - b_dov, 8);
    if (dq.size() >= b_dq + 8)
      for (int i = 0; i < 8; i++) check($sformatf("d0_byte%0d", i), dq[b_dq + i], exp_pl[i]);
    check("d0_dcomp", n_dcomp - b_dcomp, 1);
    check("d0_derr", n_derr - b_derr, 0);

    // Same packet, bad CRC16
    snap();
    pkt = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h95};
    send_pkt();
    check("d0bad_dov", n_dov - b_dov, 8);
    check("d0bad_dcomp", n_dcomp - b_dcomp, 0);
    check("d0bad_derr", n_derr - b_derr, 1);

    // Zero-length DATA1
    snap(); pkt = '{8'h4B, 8'h00, 8'h00}; send_pkt();
    check("zlp_dcomp", n_dcomp - b_dcomp, 1);
    check("zlp_dov", n_dov - b_dov, 0);

    // ACK
    snap(); pkt = '{8'hD2}; send_pkt();
    check("ack_hs", n_hs - b_hs, 1);
    check("ack_pid", bus.pid, 4'h2);
    check("ack_perr", n_perr - b_perr, 0);

    // ACK with trailing byte
    snap(); pkt = '{8'hD2, 8'h00}; send_pkt();
    check("ackx_hs", n_hs - b_hs, 0);
    check("ackx_perr", n_perr - b_perr, 1);

    // Bad PID check nibble
    snap(); pkt = '{8'h2C, 8'h00, 8'h10}; send_pkt();
    check("badpid_pidv", n_pidv - b_pidv, 0);
    check("badpid_perr", n_perr - b_perr, 1);

    // rx_error inside a token
    snap();
    p_start(); p_byte(8'h2D); p_err(); p_byte(8'h10); p_end();
    check("rxerr_tokv", n_tokv - b_tokv, 0);
    check("rxerr_perr", n_perr - b_perr, 1);

    // Oversized payload: 130 payload + 2 bytes, counter must saturate
    snap();
    p_start(); p_byte(8'hC3);
    for (int i = 0; i < 132; i++) p_byte(8'(i));
    p_end();
    check("big_dov", n_dov - b_dov, 64);
    check("big_derr", n_derr - b_derr, 1);
    check("big_dcomp", n_dcomp - b_dcomp, 0);

    // SOP while a DATA0 packet is in flight, followed by ACK
    snap();
    p_start(); p_byte(8'hC3); p_byte(8'h80); p_byte(8'h06);
    p_start(); p_byte(8'hD2); p_end();
    check("abort_derr", n_derr - b_derr, 1);
    check("abort_perr", n_perr - b_perr, 0);
    check("abort_hs", n_hs - b_hs, 1);

    // Reset in the middle of DATA0
    snap();
    p_start(); p_byte(8'hC3); p_byte(8'h80); p_byte(8'h06); p_byte(8'h00); p_byte(8'h01);
    @(negedge clk); clr(); rst_n = 1'b0;
    idle(2);
    check_outputs_zero("reset_mid");
    rst_n = 1'b1;
    idle(2);
    snap(); pkt = '{8'hD2}; send_pkt();
    check("postrst_hs", n_hs - b_hs, 1);
    check("postrst_dcomp", n_dcomp - b_dcomp, 0);
    check("postrst_derr", n_derr - b_derr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
